// File: rtl/ppu_hv_sequencer_pkg.sv
// Shared timing constants and the counter type for the PPU H/V sequencer.
package ppu_hv_sequencer_pkg;

   typedef logic [8:0] hv_cnt_t;

   localparam int NTSC_H_LAST   = 340;
   localparam int NTSC_V_LAST   = 261;
   localparam int NTSC_VBL_LINE = 241;

   localparam int PAL_H_LAST    = 340;
   localparam int PAL_V_LAST    = 311;
   localparam int PAL_VBL_LINE  = 241;

endpackage

// File: rtl/ppu_hv_sequencer_if.sv
// Counter bundle between the H/V counter pair (slave) and the sequencer top (master).
interface ppu_hv_sequencer_if;
   import ppu_hv_sequencer_pkg::*;

   logic    render_en;
   hv_cnt_t h;
   hv_cnt_t v;
   logic    odd;

   modport master (output render_en, input h, input v, input odd);
   modport slave  (input render_en, output h, output v, output odd);

endinterface

// File: rtl/ppu_hv_counter.sv
// Dot/line counter pair with frame parity. With PPU_ODD_FRAME_SKIP_EN defined, the
// last dot of the pre-render line is dropped on odd frames while rendering is on.
module ppu_hv_counter
   import ppu_hv_sequencer_pkg::*;
#(
   parameter int H_LAST = NTSC_H_LAST,
   parameter int V_LAST = NTSC_V_LAST
) (
   input  logic              clk,
   input  logic              rst_n,
   ppu_hv_sequencer_if.slave hv
);

   localparam hv_cnt_t H_MAX = hv_cnt_t'(H_LAST);
   localparam hv_cnt_t V_MAX = hv_cnt_t'(V_LAST);

   hv_cnt_t h_next;
   hv_cnt_t v_next;
   logic    odd_next;
   logic    h_wrap;
   logic    v_wrap;
   logic    skip;

`ifdef PPU_ODD_FRAME_SKIP_EN
   assign skip = hv.odd && hv.render_en && (hv.h == H_MAX - 9'd1) && (hv.v == V_MAX);
`else
   logic unused_render_en;
   assign unused_render_en = hv.render_en;
   assign skip = 1'b0;
`endif

   // Out-of-range values fall into the wrap path so they recover in one edge.
   assign h_wrap = (hv.h >= H_MAX);
   assign v_wrap = (hv.v >= V_MAX);

   always_comb begin
      h_next   = hv.h + 9'd1;
      v_next   = hv.v;
      odd_next = hv.odd;
      if (h_wrap || skip) begin
         h_next = '0;
         if (v_wrap || skip) begin
            v_next   = '0;
            odd_next = ~hv.odd;
         end else begin
            v_next = hv.v + 9'd1;
         end
      end else if (hv.v > V_MAX) begin
         v_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hv.h   <= '0;
         hv.v   <= '0;
         hv.odd <= 1'b0;
      end else begin
         hv.h   <= h_next;
         hv.v   <= v_next;
         hv.odd <= odd_next;
      end
   end

endmodule

// File: rtl/ppu_hv_sequencer.sv
// PPU raster sequencer: H/V counters, blanking, VBlank flag, NMI and status-clear pulse.
// Optional odd-frame dot skip is enabled by defining PPU_ODD_FRAME_SKIP_EN.
module ppu_hv_sequencer
   import ppu_hv_sequencer_pkg::*;
#(
   parameter int H_LAST   = NTSC_H_LAST,
   parameter int V_LAST   = NTSC_V_LAST,
   parameter int VBL_LINE = NTSC_VBL_LINE
) (
   input  logic    PCLK,
   input  logic    nRES,
   input  logic    render_en,
   input  logic    nmi_en,
   input  logic    vbl_clr,
   output hv_cnt_t H,
   output hv_cnt_t V,
   output logic    VB,
   output logic    BLNK,
   output logic    vbl_flag,
   output logic    nINT,
   output logic    odd,
   output logic    pre_clr
);

   localparam hv_cnt_t V_MAX   = hv_cnt_t'(V_LAST);
   localparam hv_cnt_t VBL_TOP = hv_cnt_t'(VBL_LINE);

   ppu_hv_sequencer_if cnt_if ();

   assign cnt_if.render_en = render_en;

   ppu_hv_counter #(
      .H_LAST (H_LAST),
      .V_LAST (V_LAST)
   ) u_counter (
      .clk   (PCLK),
      .rst_n (nRES),
      .hv    (cnt_if)
   );

   assign H   = cnt_if.h;
   assign V   = cnt_if.v;
   assign odd = cnt_if.odd;

   assign VB   = (V >= VBL_TOP) && (V < V_MAX);
   assign BLNK = VB | ~render_en;

   logic vbl_start;
   logic vbl_end;
   logic vbl_flag_next;

   assign vbl_start = (V == VBL_TOP) && (H == '0);
   assign vbl_end   = (V == V_MAX) && (H == '0);

   // A status read landing on the set edge suppresses the flag for this frame.
   always_comb begin
      vbl_flag_next = vbl_flag;
      if (vbl_clr || vbl_end) begin
         vbl_flag_next = 1'b0;
      end else if (vbl_start) begin
         vbl_flag_next = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge nRES) begin
      if (!nRES) begin
         vbl_flag <= 1'b0;
         nINT     <= 1'b1;
         pre_clr  <= 1'b0;
      end else begin
         vbl_flag <= vbl_flag_next;
         nINT     <= ~(vbl_flag & nmi_en);
         pre_clr  <= vbl_end;
      end
   end

endmodule

// File: tb/tb_ppu_hv_sequencer.sv
// Directed bench: one full NTSC-sized frame plus a reduced-geometry instance for the
// race, odd-frame and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_ppu_hv_sequencer;
   import ppu_hv_sequencer_pkg::*;

   localparam int BIG_FRAME = 341 * 262;
   localparam int S_FRAME   = 16 * 10;
`ifdef PPU_ODD_FRAME_SKIP_EN
   localparam int S_SKIP_FRAME = S_FRAME - 1;
`else
   localparam int S_SKIP_FRAME = S_FRAME;
`endif

   logic pclk = 1'b0;
   logic nres_big, nres_small;
   logic big_nmi_en, big_vbl_clr, small_nmi_en, small_vbl_clr;
   logic big_vb, big_blnk, big_vbl_flag, big_n_int, big_pre_clr;
   logic small_vb, small_blnk, small_vbl_flag, small_n_int, small_pre_clr;
   int   checks;
   int   errors;

   ppu_hv_sequencer_if big_if ();
   ppu_hv_sequencer_if small_if ();

   always #5 pclk = ~pclk;

   ppu_hv_sequencer u_big (
      .PCLK(pclk), .nRES(nres_big), .render_en(big_if.render_en), .nmi_en(big_nmi_en),
      .vbl_clr(big_vbl_clr), .H(big_if.h), .V(big_if.v), .VB(big_vb), .BLNK(big_blnk),
      .vbl_flag(big_vbl_flag), .nINT(big_n_int), .odd(big_if.odd), .pre_clr(big_pre_clr)
   );

   ppu_hv_sequencer #(.H_LAST(15), .V_LAST(9), .VBL_LINE(6)) u_small (
      .PCLK(pclk), .nRES(nres_small), .render_en(small_if.render_en), .nmi_en(small_nmi_en),
      .vbl_clr(small_vbl_clr), .H(small_if.h), .V(small_if.v), .VB(small_vb), .BLNK(small_blnk),
      .vbl_flag(small_vbl_flag), .nINT(small_n_int), .odd(small_if.odd), .pre_clr(small_pre_clr)
   );

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic run_to(input int tv, input int th, input int budget, input string name);
      int k;
      k = 0;
      while (!(small_if.v == tv && small_if.h == th) && k < budget) begin
         step();
         k++;
      end
      checks++;
      if (!(small_if.v == tv && small_if.h == th)) begin
         errors++;
         $display("FAIL %s: timeout at V=%0d H=%0d, want V=%0d H=%0d", name, small_if.v, small_if.h, tv, th);
      end
   endtask

   task automatic measure_frame(output int len);
      len = 0;
      do begin
         step();
         len++;
      end while (!(small_if.v == 0 && small_if.h == 0) && len < 400);
   endtask

   task automatic reset_small();
      nres_small = 1'b0;
      step();
      step();
      nres_small = 1'b1;
   endtask

   task automatic test_reset();
      nres_big = 1'b1; nres_small = 1'b1;
      big_if.render_en = 1'b0; big_nmi_en = 1'b0; big_vbl_clr = 1'b0;
      small_if.render_en = 1'b0; small_nmi_en = 1'b0; small_vbl_clr = 1'b0;
      #2;
      nres_big = 1'b0; nres_small = 1'b0;
      #1;
      checks++; if (big_if.h !== 9'd0) begin errors++; $display("FAIL reset_h: got %0d want 0", big_if.h); end
      checks++; if (big_if.v !== 9'd0) begin errors++; $display("FAIL reset_v: got %0d want 0", big_if.v); end
      checks++; if (big_vbl_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", big_vbl_flag); end
      checks++; if (big_if.odd !== 1'b0) begin errors++; $display("FAIL reset_odd: got %b want 0", big_if.odd); end
      checks++; if (big_pre_clr !== 1'b0) begin errors++; $display("FAIL reset_pre_clr: got %b want 0", big_pre_clr); end
      checks++; if (big_n_int !== 1'b1) begin errors++; $display("FAIL reset_nint: got %b want 1", big_n_int); end
      checks++; if ({big_vb, big_blnk} !== 2'b01) begin errors++; $display("FAIL reset_vb_blnk: got %b want 01", {big_vb, big_blnk}); end
      step();
      step();
      nres_big = 1'b1; nres_small = 1'b1;
   endtask

   // Full default-geometry frame: wrap points, VBlank entry, NMI, pre-render clear.
   task automatic test_big_frame();
      int pre_cnt;
      pre_cnt = 0;
      big_nmi_en = 1'b1;
      big_if.render_en = 1'b1;
      for (int n = 1; n <= BIG_FRAME; n++) begin
         step();
         if (big_pre_clr === 1'b1) pre_cnt++;
         case (n)
            1: begin
               checks++; if ({big_if.v, big_if.h} !== {9'd0, 9'd1}) begin errors++; $display("FAIL first_edge: got V=%0d H=%0d want V=0 H=1", big_if.v, big_if.h); end
            end
            341: begin
               checks++; if ({big_if.v, big_if.h} !== {9'd1, 9'd0}) begin errors++; $display("FAIL h_wrap: got V=%0d H=%0d want V=1 H=0", big_if.v, big_if.h); end
            end
            82180: begin
               checks++; if ({big_vb, big_blnk} !== 2'b00) begin errors++; $display("FAIL pre_vbl_window: got %b want 00", {big_vb, big_blnk}); end
            end
            82181: begin
               checks++; if ({big_if.v, big_if.h} !== {9'd241, 9'd0}) begin errors++; $display("FAIL vbl_pos: got V=%0d H=%0d want V=241 H=0", big_if.v, big_if.h); end
               checks++; if (big_vbl_flag !== 1'b0) begin errors++; $display("FAIL vbl_flag_h0: got %b want 0", big_vbl_flag); end
               checks++; if ({big_vb, big_blnk} !== 2'b11) begin errors++; $display("FAIL vbl_window: got %b want 11", {big_vb, big_blnk}); end
            end
            82182: begin
               checks++; if (big_vbl_flag !== 1'b1) begin errors++; $display("FAIL vbl_flag_h1: got %b want 1", big_vbl_flag); end
               checks++; if (big_n_int !== 1'b1) begin errors++; $display("FAIL nint_h1: got %b want 1", big_n_int); end
            end
            82183: begin
               checks++; if (big_n_int !== 1'b0) begin errors++; $display("FAIL nint_h2: got %b want 0", big_n_int); end
            end
            82190: big_nmi_en = 1'b0;
            82191: begin
               checks++; if (big_n_int !== 1'b1) begin errors++; $display("FAIL nint_masked: got %b want 1", big_n_int); end
               big_nmi_en = 1'b1;
            end
            82192: begin
               checks++; if (big_n_int !== 1'b0) begin errors++; $display("FAIL nint_reenable: got %b want 0", big_n_int); end
            end
            89001: begin
               checks++; if ({big_if.v, big_if.h} !== {9'd261, 9'd0}) begin errors++; $display("FAIL prerender_pos: got V=%0d H=%0d want V=261 H=0", big_if.v, big_if.h); end
               checks++; if ({big_vbl_flag, big_vb} !== 2'b10) begin errors++; $display("FAIL prerender_flag_vb: got %b want 10", {big_vbl_flag, big_vb}); end
            end
            89002: begin
               checks++; if ({big_pre_clr, big_vbl_flag} !== 2'b10) begin errors++; $display("FAIL pre_clr_h1: got %b want 10", {big_pre_clr, big_vbl_flag}); end
            end
            89003: begin
               checks++; if ({big_pre_clr, big_n_int} !== 2'b01) begin errors++; $display("FAIL pre_clr_h2: got %b want 01", {big_pre_clr, big_n_int}); end
            end
            89341: begin
               checks++; if ({big_if.v, big_if.h} !== {9'd261, 9'd340}) begin errors++; $display("FAIL last_dot: got V=%0d H=%0d want V=261 H=340", big_if.v, big_if.h); end
            end
            89342: begin
               checks++; if ({big_if.v, big_if.h, big_if.odd} !== {9'd0, 9'd0, 1'b1}) begin errors++; $display("FAIL frame_wrap: got V=%0d H=%0d odd=%b want 0 0 1", big_if.v, big_if.h, big_if.odd); end
            end
            default: ;
         endcase
      end
      checks++; if (pre_cnt !== 1) begin errors++; $display("FAIL pre_clr_count: got %0d want 1", pre_cnt); end
      big_if.render_en = 1'b0;
   endtask

   task automatic test_vbl_clr_race();
      int bad;
      reset_small();
      small_if.render_en = 1'b0;
      small_nmi_en = 1'b1;
      for (int n = 1; n <= 96; n++) step();
      checks++; if ({small_if.v, small_if.h} !== {9'd6, 9'd0}) begin errors++; $display("FAIL race_pos: got V=%0d H=%0d want V=6 H=0", small_if.v, small_if.h); end
      small_vbl_clr = 1'b1;
      step();
      small_vbl_clr = 1'b0;
      checks++; if (small_vbl_flag !== 1'b0) begin errors++; $display("FAIL race_flag: got %b want 0", small_vbl_flag); end
      bad = 0;
      for (int n = 98; n <= 145; n++) begin
         step();
         if (small_vbl_flag !== 1'b0 || small_n_int !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL race_hold: got %0d bad cycles want 0", bad); end
      checks++; if ({small_if.v, small_if.h, small_pre_clr} !== {9'd9, 9'd1, 1'b1}) begin errors++; $display("FAIL race_pre_clr: got V=%0d H=%0d pre_clr=%b want 9 1 1", small_if.v, small_if.h, small_pre_clr); end
   endtask

   task automatic test_vbl_clr_mid();
      run_to(7, 3, 400, "mid_run");
      checks++; if ({small_vbl_flag, small_n_int} !== 2'b10) begin errors++; $display("FAIL mid_before: got %b want 10", {small_vbl_flag, small_n_int}); end
      small_vbl_clr = 1'b1;
      step();
      small_vbl_clr = 1'b0;
      checks++; if ({small_vbl_flag, small_n_int} !== 2'b00) begin errors++; $display("FAIL mid_clear: got %b want 00", {small_vbl_flag, small_n_int}); end
      step();
      checks++; if ({small_vbl_flag, small_n_int} !== 2'b01) begin errors++; $display("FAIL mid_release: got %b want 01", {small_vbl_flag, small_n_int}); end
   endtask

   task automatic test_odd_skip();
      int len;
      reset_small();
      small_nmi_en = 1'b0;
      small_if.render_en = 1'b1;
      measure_frame(len);
      checks++; if (len !== S_FRAME || small_if.odd !== 1'b1) begin errors++; $display("FAIL even_frame: got len=%0d odd=%b want %0d 1", len, small_if.odd, S_FRAME); end
      measure_frame(len);
      checks++; if (len !== S_SKIP_FRAME || small_if.odd !== 1'b0) begin errors++; $display("FAIL odd_render_frame: got len=%0d odd=%b want %0d 0", len, small_if.odd, S_SKIP_FRAME); end
      measure_frame(len);
      checks++; if (len !== S_FRAME || small_if.odd !== 1'b1) begin errors++; $display("FAIL even_frame2: got len=%0d odd=%b want %0d 1", len, small_if.odd, S_FRAME); end
      small_if.render_en = 1'b0;
      measure_frame(len);
      checks++; if (len !== S_FRAME || small_if.odd !== 1'b0) begin errors++; $display("FAIL odd_idle_frame: got len=%0d odd=%b want %0d 0", len, small_if.odd, S_FRAME); end
   endtask

   task automatic test_reset_mid();
      int len;
      reset_small();
      small_if.render_en = 1'b0;
      small_nmi_en = 1'b1;
      measure_frame(len);
      run_to(8, 4, 400, "rst_mid_run");
      checks++; if ({small_vbl_flag, small_n_int, small_if.odd} !== 3'b101) begin errors++; $display("FAIL rst_mid_before: got %b want 101", {small_vbl_flag, small_n_int, small_if.odd}); end
      #2;
      nres_small = 1'b0;
      #1;
      checks++; if ({small_if.v, small_if.h} !== 18'd0) begin errors++; $display("FAIL rst_mid_hv: got V=%0d H=%0d want 0 0", small_if.v, small_if.h); end
      checks++; if ({small_vbl_flag, small_if.odd, small_pre_clr, small_n_int} !== 4'b0001) begin errors++; $display("FAIL rst_mid_state: got %b want 0001", {small_vbl_flag, small_if.odd, small_pre_clr, small_n_int}); end
      step();
      step();
      nres_small = 1'b1;
      step();
      step();
      checks++; if ({small_if.v, small_if.h, small_vbl_flag, small_n_int} !== {9'd0, 9'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL rst_mid_resume: got V=%0d H=%0d flag=%b nint=%b want 0 2 0 1", small_if.v, small_if.h, small_vbl_flag, small_n_int); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_big_frame();
      test_vbl_clr_race();
      test_vbl_clr_mid();
      test_odd_skip();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
